// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble wins over hold, otherwise loads the fetched word.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= 32'h0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_pc    <= 32'h0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, BOOT/RUN/HALT control and the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_inst,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_inst,
    output logic               ifid_valid,
    output logic               halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_redirect_aligned;
    logic         w_is_ebreak;
    logic         w_ifid_hold;
    logic         w_ifid_bubble;

    assign w_redirect_aligned = redirect_pc & ~32'h3;
    assign w_is_ebreak        = (imem_inst == EBREAK_INST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FS_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A redirect overrides stall and every state, including BOOT.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = FS_RUN;
        end else if (!stall) begin
            case (r_state)
                FS_BOOT: w_state_next = FS_RUN;
                FS_RUN:  w_state_next = w_is_ebreak ? FS_HALT : FS_RUN;
                FS_HALT: w_state_next = FS_HALT;
                default: w_state_next = FS_BOOT;
            endcase
        end
    end

    always_comb begin
        w_pc_next     = r_pc;
        w_ifid_hold   = 1'b0;
        w_ifid_bubble = 1'b0;
        if (redirect_valid) begin
            w_pc_next     = w_redirect_aligned;
            w_ifid_bubble = 1'b1;
        end else if (stall) begin
            w_ifid_hold = 1'b1;
        end else begin
            case (r_state)
                FS_RUN: begin
                    // EBREAK is latched but the PC parks on it.
                    if (!w_is_ebreak) begin
                        w_pc_next = r_pc + 32'd4;
                    end
                end
                default: w_ifid_bubble = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC & ~32'h3;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_ifid_hold),
        .i_bubble (w_ifid_bubble),
        .i_pc     (r_pc),
        .i_inst   (imem_inst),
        .o_pc     (ifid_pc),
        .o_inst   (ifid_inst),
        .o_valid  (ifid_valid)
    );

    assign imem_addr = r_pc[IMEM_AW-1:0];
    assign halted    = (r_state == FS_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/reset traffic vs a reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        halted;

    logic [31:0] mem [1024];

    int n_compared;
    int n_mismatched;

    // reference model: architectural view of the fetch stage
    logic [31:0] m_pc;
    bit          m_booting;
    bit          m_halted;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_inst;
    bit          m_ifid_valid;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .ifid_pc        (ifid_pc),
        .ifid_inst      (ifid_inst),
        .ifid_valid     (ifid_valid),
        .halted         (halted)
    );

    assign imem_inst = mem[imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc         = 32'h0;
        m_booting    = 1'b1;
        m_halted     = 1'b0;
        m_ifid_pc    = 32'h0;
        m_ifid_inst  = NOP;
        m_ifid_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_ifid_pc    = 32'h0;
        m_ifid_inst  = NOP;
        m_ifid_valid = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit rv, input logic [31:0] rpc);
        logic [31:0] word;
        if (rv) begin
            m_pc      = {rpc[31:2], 2'b00};
            m_booting = 1'b0;
            m_halted  = 1'b0;
            model_bubble();
        end else if (s) begin
            // everything frozen
        end else if (m_booting) begin
            m_booting = 1'b0;
            model_bubble();
        end else if (m_halted) begin
            model_bubble();
        end else begin
            word         = mem[m_pc[11:2]];
            m_ifid_pc    = m_pc;
            m_ifid_inst  = word;
            m_ifid_valid = 1'b1;
            if (word == EBREAK) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".imem_addr"},  {20'h0, imem_addr}, m_pc & 32'hFFF);
        check_eq({tag, ".ifid_pc"},    ifid_pc, m_ifid_pc);
        check_eq({tag, ".ifid_inst"},  ifid_inst, m_ifid_inst);
        check_eq({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_ifid_valid});
        check_eq({tag, ".halted"},     {31'h0, halted}, {31'h0, m_halted});
    endtask

    // Drive one cycle's inputs, advance one edge, then compare against the model.
    task automatic cycle(input string tag, input bit s, input bit rv, input logic [31:0] rpc);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(s, rv, rpc);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".imem_addr"},  {20'h0, imem_addr}, 32'h0);
        check_eq({tag, ".ifid_pc"},    ifid_pc, 32'h0);
        check_eq({tag, ".ifid_inst"},  ifid_inst, NOP);
        check_eq({tag, ".ifid_valid"}, {31'h0, ifid_valid}, 32'h0);
        check_eq({tag, ".halted"},     {31'h0, halted}, 32'h0);
    endtask

    // Reset asserted between edges; outputs must follow without a clock edge.
    task automatic reset_now(input string tag);
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = NOP;
        model_reset();

        // reset release on an all-NOP memory
        @(posedge clk);
        #1;
        check_reset_values("por");
        rst = 1'b0;
        cycle("boot", 1'b0, 1'b0, 32'h0);
        check_eq("boot_bubble", {31'h0, ifid_valid}, 32'h0);
        for (int i = 0; i < 2; i++) cycle("run_seq", 1'b0, 1'b0, 32'h0);

        // stall for 3 cycles at pc 8
        check_eq("pre_stall_addr", {20'h0, imem_addr}, 32'h8);
        for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 32'h0);
        check_eq("stall_ifid_pc", ifid_pc, 32'h4);
        for (int i = 0; i < 2; i++) cycle("resume", 1'b0, 1'b0, 32'h0);

        // redirect with simultaneous stall, unaligned target
        cycle("redir_stall", 1'b1, 1'b1, 32'h0000_0103);
        check_eq("redir_addr", {20'h0, imem_addr}, 32'h100);
        cycle("redir_fetch", 1'b0, 1'b0, 32'h0);
        check_eq("redir_ifid_pc", ifid_pc, 32'h100);
        check_eq("redir_ifid_valid", {31'h0, ifid_valid}, 32'h1);

        // EBREAK at 0x10 halts the stage until a redirect
        mem[4] = EBREAK;
        cycle("to_zero", 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) cycle("to_ebreak", 1'b0, 1'b0, 32'h0);
        check_eq("ebreak_inst", ifid_inst, EBREAK);
        check_eq("ebreak_pc", ifid_pc, 32'h10);
        for (int i = 0; i < 3; i++) cycle("halt", 1'b0, 1'b0, 32'h0);
        check_eq("halt_flag", {31'h0, halted}, 32'h1);
        check_eq("halt_addr", {20'h0, imem_addr}, 32'h10);
        cycle("unhalt", 1'b0, 1'b1, 32'h20);
        check_eq("unhalt_flag", {31'h0, halted}, 32'h0);
        cycle("after_unhalt", 1'b0, 1'b0, 32'h0);

        // pc wrap from the top of the address space
        cycle("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle("wrap", 1'b0, 1'b0, 32'h0);
        check_eq("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        check_eq("wrap_addr", {20'h0, imem_addr}, 32'h0);
        cycle("wrap2", 1'b0, 1'b0, 32'h0);

        // asynchronous reset in the middle of a stall
        stall = 1'b1;
        reset_now("mid_reset");
        for (int i = 0; i < 3; i++) cycle("post_reset", 1'b0, 1'b0, 32'h0);

        // random traffic over a random program
        for (int i = 0; i < 1024; i++) begin
            mem[i] = ($urandom_range(0, 19) == 0) ? EBREAK : $urandom;
        end
        for (int i = 0; i < 600; i++) begin
            bit          s;
            bit          rv;
            logic [31:0] rpc;
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 149) == 0) reset_now("rand_reset");
            else cycle("rand", s, rv, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 12, meaning the instruction-memory byte-address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  meaning the decode stage cannot accept; hold PC and IF/ID.
REQ-006 SHALL have port redirect_valid  input  1  meaning a taken branch/jump from a later stage.
REQ-007 SHALL have port redirect_pc  input  32  meaning the target PC of the redirect.
REQ-008 SHALL have port imem_addr  output  IMEM_AW  meaning the byte address to instruction memory (combinational read).
REQ-009 SHALL have port imem_inst  input  32  meaning the word returned by instruction memory in the same cycle.
REQ-010 SHALL have port ifid_pc  output  32  meaning the PC of the instruction held in IF/ID.
REQ-011 SHALL have port ifid_inst  output  32  meaning the instruction held in IF/ID.
REQ-012 SHALL have port ifid_valid  output  1  meaning IF/ID holds a real instruction (not a bubble).
REQ-013 SHALL have port halted  output  1  meaning the fetch FSM is in HALT.

Function
REQ-014 SHALL drive imem_addr = pc[IMEM_AW-1:0] combinationally, with pc[1:0] always 2'b00.
REQ-015 SHALL implement FSM states BOOT, RUN and HALT; BOOT SHALL last exactly one cycle, then go to RUN with no fetch.
REQ-016 SHALL, in BOOT, hold pc and load IF/ID with a bubble: inst 32'h0000_0013, valid 0, pc 0.
REQ-017 SHALL, in RUN with no stall and no redirect, load IF/ID with {pc, imem_inst, valid 1} and set pc <= pc + 4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0).
REQ-018 SHALL, in RUN with no stall and no redirect and imem_inst == 32'h0010_0073 (EBREAK), latch that instruction as in REQ-017, hold pc unchanged, and enter HALT.
REQ-019 SHALL, in HALT, hold pc and load a bubble into IF/ID each cycle.
REQ-020 SHALL, when stall = 1 and redirect_valid = 0, hold pc, IF/ID and the FSM state unchanged in every state.
REQ-021 SHALL give redirect_valid priority over stall, EBREAK detection and the FSM: set pc <= {redirect_pc[31:2], 2'b00}, load a bubble into IF/ID, and set state <= RUN from any state, including BOOT.
REQ-022 SHALL fetch the redirect target on the cycle after the redirect, with latency 1 cycle from redirect to a valid IF/ID entry at the target.
REQ-023 SHALL make halted = 1 exactly when state == HALT.
REQ-024 SHALL make all IF/ID outputs registered, with no combinational path from imem_inst to any ifid_* output.

Reset
REQ-025 SHALL, while rst = 1 (asynchronous): pc = RESET_PC aligned, state = BOOT, ifid_pc = 0, ifid_inst = 32'h0000_0013, ifid_valid = 0, halted = 0.
REQ-026 SHALL discard any in-flight fetch, stall or redirect when rst asserts mid-operation, and restart with BOOT after deassertion.

Structure
REQ-027 SHALL take the constants NOP_INST (32'h0000_0013), EBREAK_INST (32'h0010_0073) and the fetch-state enum from the shared package riscv_pkg.
REQ-028 SHALL be a single module, with the IF/ID register as an optional sub-module if_id_reg (pc, inst, valid; hold/bubble controls).

Verification
REQ-029 SHALL cover reset release with RESET_PC = 0 and an all-NOP memory -> one BOOT cycle; imem_addr sequence 0, 4, 8, ...; ifid_valid = 1 from the 3rd edge.
REQ-030 SHALL cover stall held 3 cycles at pc = 8 -> imem_addr stays 8; ifid_pc/ifid_inst unchanged; resumes at 8 then 12.
REQ-031 SHALL cover redirect_valid = 1 with redirect_pc = 32'h0000_0103 together with stall = 1 -> next cycle imem_addr = 0x100 and ifid_valid = 0; the following cycle ifid_pc = 0x100 and ifid_valid = 1.
REQ-032 SHALL cover EBREAK at address 0x10 -> ifid_inst = 32'h0010_0073 at ifid_pc 0x10, then halted = 1, bubbles, imem_addr stuck at 0x10; a later redirect to 0x20 clears halted.
REQ-033 SHALL cover pc preloaded to 32'hFFFF_FFFC via redirect -> next pc is 0 and imem_addr wraps to 0.
REQ-034 SHALL cover rst asserted mid-run with stall = 1 -> outputs equal the reset values immediately, without waiting for a clock edge.
